// File: rtl/iic_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : iic_xfer_sequencer
// Purpose  : Sequences I2C address/command/data byte slots for a bit engine.
//            Optional watchdog when IIC_SEQ_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module iic_xfer_sequencer #(
    parameter logic [6:0] DEV_ADDR = 7'b1010000,
    parameter int         CMD_LEN  = 1,
    parameter int         MAX_LEN  = 16,
    parameter int         LEN_W    = 8,
    parameter int         TIMEOUT  = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trig,
    input  logic                 is_read,
    input  logic [CMD_LEN*8-1:0] cmd,
    input  logic [LEN_W-1:0]     len,
    input  logic [7:0]           wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic [7:0]           byte_data,
    output logic                 byte_valid,
    output logic                 byte_start,
    output logic                 byte_stop,
    output logic                 byte_rd,
    output logic                 byte_nack,
    input  logic                 byte_ready,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ADDR_W  = 3'd1;
    localparam logic [2:0] CMD     = 3'd2;
    localparam logic [2:0] DATA_W  = 3'd3;
    localparam logic [2:0] ADDR_R  = 3'd4;
    localparam logic [2:0] DATA_R  = 3'd5;
    localparam logic [2:0] WAIT_RX = 3'd6;
    localparam logic [2:0] FINISH  = 3'd7;

    localparam logic [LEN_W-1:0] C_ONE     = LEN_W'(1);
    localparam logic [LEN_W-1:0] C_CMD_END = LEN_W'(CMD_LEN - 1);
    localparam logic [LEN_W:0]   C_MAX_LEN = (LEN_W + 1)'(MAX_LEN);

    logic [2:0]           r_state;
    logic [LEN_W-1:0]     r_cnt;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_rx_cnt;
    logic [CMD_LEN*8-1:0] r_cmd;
    logic                 r_is_read;
    logic                 r_err;
    logic                 r_rd_valid;
    logic [7:0]           r_rd_data;

    logic w_hs;
    logic w_last;
    logic w_len_ok;
    logic w_rx_hit;
    logic w_wd_fire;

    assign w_hs     = byte_valid & byte_ready;
    assign w_last   = (r_cnt == r_len - C_ONE);
    assign w_len_ok = (len != '0) && ({1'b0, len} <= C_MAX_LEN);
    assign w_rx_hit = rx_valid && ((r_state == DATA_R) || (r_state == WAIT_RX));

`ifdef IIC_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wd;
    logic            w_wd_run;

    // Counts stalled-slot cycles and rx-wait cycles; any progress restarts it.
    assign w_wd_run  = (byte_valid && !byte_ready) || (r_state == WAIT_RX);
    assign w_wd_fire = w_wd_run && (r_wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || !w_wd_run || w_hs || rx_valid || w_wd_fire) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 1'b1;
        end
    end
`else
    assign w_wd_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_rx_cnt   <= '0;
            r_cmd      <= '0;
            r_is_read  <= 1'b0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
        end else begin
            r_err      <= 1'b0;
            r_rd_valid <= w_rx_hit;
            if (w_rx_hit) begin
                r_rd_data <= rx_data;
                r_rx_cnt  <= r_rx_cnt + C_ONE;
            end
            if (w_wd_fire) begin
                r_state <= IDLE;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (trig) begin
                            if (w_len_ok) begin
                                r_state   <= ADDR_W;
                                r_cnt     <= '0;
                                r_rx_cnt  <= '0;
                                r_len     <= len;
                                r_cmd     <= cmd;
                                r_is_read <= is_read;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    ADDR_W: begin
                        if (w_hs) begin
                            r_state <= CMD;
                            r_cnt   <= '0;
                        end
                    end
                    CMD: begin
                        if (w_hs) begin
                            r_cmd <= r_cmd << 8;
                            if (r_cnt == C_CMD_END) begin
                                r_state <= r_is_read ? ADDR_R : DATA_W;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + C_ONE;
                            end
                        end
                    end
                    DATA_W: begin
                        if (w_hs) begin
                            if (w_last) begin
                                r_state <= FINISH;
                            end else begin
                                r_cnt <= r_cnt + C_ONE;
                            end
                        end
                    end
                    ADDR_R: begin
                        if (w_hs) begin
                            r_state <= DATA_R;
                            r_cnt   <= '0;
                        end
                    end
                    DATA_R: begin
                        if (w_hs) begin
                            if (w_last) begin
                                r_state <= WAIT_RX;
                            end else begin
                                r_cnt <= r_cnt + C_ONE;
                            end
                        end
                    end
                    WAIT_RX: begin
                        if (r_rx_cnt == r_len) begin
                            r_state <= FINISH;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Slot fields are pure decodes of state, so they hold while stalled.
    always_comb begin
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        byte_start = 1'b0;
        byte_stop  = 1'b0;
        byte_rd    = 1'b0;
        byte_nack  = 1'b0;
        wr_ready   = 1'b0;
        case (r_state)
            ADDR_W: begin
                byte_data  = {DEV_ADDR, 1'b0};
                byte_valid = 1'b1;
                byte_start = 1'b1;
            end
            CMD: begin
                byte_data  = r_cmd[CMD_LEN*8-1 -: 8];
                byte_valid = 1'b1;
            end
            DATA_W: begin
                byte_data  = wr_data;
                byte_valid = wr_valid;
                byte_stop  = w_last;
                wr_ready   = wr_valid & byte_ready;
            end
            ADDR_R: begin
                byte_data  = {DEV_ADDR, 1'b1};
                byte_valid = 1'b1;
                byte_start = 1'b1;
            end
            DATA_R: begin
                byte_data  = 8'hff;
                byte_valid = 1'b1;
                byte_rd    = 1'b1;
                byte_nack  = w_last;
                byte_stop  = w_last;
            end
            default: begin
            end
        endcase
    end

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == FINISH);
    assign err      = r_err;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule
`default_nettype wire

// File: doc/iic_xfer_sequencer.md
IIC_XFER_SEQUENCER -- requirements
Module: iic_xfer_sequencer

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'b1010000, 7-bit slave address.
REQ-002 SHALL have parameter CMD_LEN, default 1, command/word-address bytes (1..4).
REQ-003 SHALL have parameter MAX_LEN, default 16, maximum data bytes per transfer (1..256).
REQ-004 SHALL have parameter LEN_W, default 8, width of len and the internal byte counters.
REQ-005 SHALL have parameter TIMEOUT, default 1000, watchdog limit in clk cycles (used only with IIC_SEQ_TIMEOUT_EN).
REQ-006 SHALL have ports, with one clock and a synchronous active-high reset:
- clk  in  1  sole clock, all logic on its rising edge
- rst  in  1  synchronous active-high reset
- trig  in  1  start-transfer pulse
- is_read  in  1  1 = read transfer, 0 = write; sampled on an accepted trig
- cmd  in  CMD_LEN*8  command bytes, MSB byte sent first; sampled on an accepted trig
- len  in  LEN_W  data byte count; sampled on an accepted trig
- wr_data  in  8  write payload byte
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  wr_data consumed this cycle
- byte_data  out  8  byte for the bit engine
- byte_valid  out  1  byte slot valid
- byte_start  out  1  slot is preceded by START (or repeated START)
- byte_stop  out  1  STOP follows this slot
- byte_rd  out  1  slot is a read (byte_data = 8'hff)
- byte_nack  out  1  master NACKs this read slot
- byte_ready  in  1  engine accepts the slot
- rx_data  in  8  byte received from the engine
- rx_valid  in  1  rx_data valid, one-cycle pulse
- rd_data  out  8  received byte
- rd_valid  out  1  rd_data valid, one-cycle pulse
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- err  out  1  one-cycle pulse on abort

Function
REQ-007 SHALL use FSM states IDLE, ADDR_W, CMD, DATA_W, ADDR_R, DATA_R, WAIT_RX, FINISH.
REQ-008 SHALL accept trig only in IDLE, and only when 1<=len<=MAX_LEN; it SHALL raise busy on the next cycle and enter ADDR_W. trig while busy SHALL be ignored. In IDLE, len=0 or len>MAX_LEN SHALL pulse err and leave busy low.
REQ-009 ADDR_W SHALL present {DEV_ADDR,1'b0} with byte_start=1; CMD SHALL present the CMD_LEN cmd bytes, MSB first.
REQ-010 Write transfers SHALL go CMD->DATA_W for len bytes taken from wr_data; wr_ready SHALL pulse in the cycle that a DATA_W slot is accepted. byte_valid SHALL stay low while wr_valid is low.
REQ-011 Read transfers SHALL go CMD->ADDR_R, which presents {DEV_ADDR,1'b1} with byte_start=1 (repeated START), then DATA_R presents len slots with byte_rd=1 and byte_data=8'hff.
REQ-012 byte_nack SHALL be 1 only on the last read slot; byte_stop SHALL be 1 only on the final slot of the transfer.
REQ-013 A slot SHALL transfer when byte_valid&byte_ready are high on a clock edge; byte_* SHALL stay stable while byte_valid=1 and byte_ready=0; the next slot SHALL be valid no earlier than the following cycle.
REQ-014 Each rx_valid during a read SHALL produce rd_data=rx_data with rd_valid one cycle later. rx_valid outside a read SHALL be ignored.
REQ-015 After the last slot is accepted, a write SHALL go to FINISH. A read SHALL go to WAIT_RX until len rx_valid pulses have arrived, then to FINISH. FINISH SHALL pulse done for one cycle, clear busy, and return to IDLE.
REQ-016 The byte counter SHALL count from 0 to len-1 with no wrap, and SHALL restart at 0 in every phase.

Reset
REQ-017 With rst=1 on a clock edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 (byte_data=8'h00). This SHALL apply mid-transfer with no STOP issued, and rst SHALL override a simultaneous trig.

Configuration
REQ-018 With IIC_SEQ_TIMEOUT_EN defined, a watchdog SHALL count cycles while byte_valid=1 and byte_ready=0, or while in WAIT_RX. On reaching TIMEOUT it SHALL pulse err, drop byte_valid, and return to IDLE without done. The counter SHALL clear on every handshake or rx_valid.
REQ-019 Without IIC_SEQ_TIMEOUT_EN there SHALL be no watchdog logic, and the block SHALL wait indefinitely.

Verification
REQ-020 Write: is_read=0, cmd=8'h00, len=3, wr_data ff,00,ff, byte_ready always 1 -> slots A0(start),00,ff,00,ff(stop), 3 wr_ready pulses, one done pulse.
REQ-021 Read: is_read=1, cmd=8'h10, len=2, rx 5a,c3 -> slots A0(start),10,A1(start),ff(rd),ff(rd,nack,stop); rd_data 5a then c3; done after the second rd_valid.
REQ-022 Backpressure: byte_ready low for 5 cycles on the cmd slot -> byte_data stays 8'h00, valid held, sequence otherwise unchanged; trig issued mid-transfer has no effect.
REQ-023 rst asserted during DATA_W byte 2 together with trig -> next cycle IDLE, all outputs 0, no done.
REQ-024 len=0 at trig -> err pulse, busy stays 0; with IIC_SEQ_TIMEOUT_EN and TIMEOUT=20, byte_ready held low -> err at cycle 20, FSM returns to IDLE.
